ucode_sequencer: RTL
====================

# ucode_sequencer

Parametrised microcode sequencer for the bytecode translation front end. It accepts one bytecode opcode at a time over a valid/ready handshake and looks up the opcode's entry micro-address in a writable dispatch table. It then walks a writable next-address table, emitting one micro-address per accepted beat to the ARM emitter until the chain terminates. It replaces the fixed next-address ROM with runtime-loadable tables, explicit termination and illegal-entry detection, backpressure, and a runaway-loop guard.

## Interface
- OP_W, 9, opcode width; dispatch table depth 2^OP_W
- ADDR_W, 9, micro-address width; next table depth 2^ADDR_W
- MAX_STEPS, 64, maximum micro-addresses emitted per opcode before abort
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- op_valid  in  1  opcode offered
- op_data  in  OP_W  opcode
- op_ready  out  1  sequencer can accept an opcode
- cfg_we  in  1  table write strobe
- cfg_sel  in  1  0 = dispatch table, 1 = next table
- cfg_addr  in  ADDR_W  write index; dispatch table uses low OP_W bits
- cfg_data  in  ADDR_W  entry value
- uaddr_valid  out  1  micro-address presented
- uaddr  out  ADDR_W  current micro-address
- uaddr_ready  in  1  emitter consumes micro-address
- seq_done  out  1  one-cycle pulse when a chain ends normally
- illegal  out  1  one-cycle pulse on illegal dispatch, illegal link or step overflow
- busy  out  1  state is RUN

## Operation
- Entry value 0 means "end of chain". All-ones (2^ADDR_W − 1) means "invalid".
- Each table has one valid bit per entry. Valid bits clear on reset. An entry that has not been written reads as all-ones, i.e. invalid.
- Table writes:
  - A write takes effect when cfg_we=1 and state is IDLE.
  - In RUN, cfg_we is ignored and has no effect.
  - op_ready = IDLE & !cfg_we, so a write cycle never accepts an opcode.
- IDLE:
  - On op_valid & op_ready, read d = dispatch[op_data].
  - If d is 0 or all-ones: pulse illegal and stay in IDLE.
  - Otherwise: upc ← d, step ← 1, go to RUN.
- RUN:
  - uaddr_valid=1 and uaddr=upc. Both are held stable until uaddr_ready.
  - On uaddr_ready, read n = next[upc] and apply the first matching rule:
    - n = 0: pulse seq_done, go to IDLE.
    - n = all-ones: pulse illegal, go to IDLE.
    - step = MAX_STEPS: pulse illegal, go to IDLE.
    - Otherwise: upc ← n, step ← step+1.
- step counter is clog2(MAX_STEPS+1) bits wide and never wraps.
- Reset asserted mid-sequence: the chain aborts immediately. No seq_done or illegal pulse is generated. Table contents are invalidated.

## Timing
- Reset values:
  - uaddr_valid=0, uaddr=0, seq_done=0, illegal=0, busy=0.
  - State is IDLE.
  - op_ready=0 while rst is asserted, and 1 in the first cycle after release if cfg_we=0.
- Opcode accepted at edge N → uaddr_valid=1 with uaddr=dispatch value from cycle N+1. No bubble.
- A chain of k addresses with uaddr_ready held high emits k beats on consecutive cycles. On the edge of the last beat:
  - seq_done pulses in the cycle after that edge.
  - State returns to IDLE, so op_ready=1 in the same cycle as the seq_done pulse.
- An illegal dispatch pulses illegal in cycle N+1. uaddr_valid stays 0.
- Table reads are combinational from registered arrays. A write at edge M is visible to a lookup in cycle M+1.
- seq_done and illegal are registered and never high together.

## Test plan
- Load dispatch[0x64]=258, next[258]=257, next[257]=0. Offer op 0x64 with uaddr_ready=1 → uaddr 258 then 257 on consecutive cycles, then seq_done pulse, then op_ready=1.
- Same load, but uaddr_ready low for 3 cycles while uaddr=258 → 258 held stable for 4 cycles, then 257, then seq_done; no beat lost or duplicated.
- Offer op 0x61 (dispatch entry never written) → illegal pulse in cycle N+1; uaddr_valid stays 0; the next opcode is accepted normally.
- Load dispatch[0x60]=256 and next[256]=256 (self-loop), MAX_STEPS=64 → exactly 64 beats of uaddr=256, then illegal pulse, state returns to IDLE.
- Assert cfg_we (next[257]=300) during RUN → write ignored (next[257] still reads 0); op_ready=0 throughout.
- Assert rst during the beat at uaddr=258 → next cycle uaddr_valid=0, busy=0, no seq_done or illegal pulse; after release, op 0x64 raises illegal because the tables were invalidated.

Source files
------------

// File: rtl/ucode_sequencer_if.sv
// Purpose : opcode / table-config / micro-address bundle between the bytecode
//           front end, the ucode_sequencer and the ARM emitter.
// Ports   : op_* opcode handshake, cfg_* table writes, uaddr_* micro-address
//           handshake, seq_done / illegal event pulses, busy status.
//           master = front end + emitter side, slave = sequencer side.
interface ucode_sequencer_if #(
  parameter int OP_W   = 9,
  parameter int ADDR_W = 9
);
  logic              op_valid;
  logic [OP_W-1:0]   op_data;
  logic              op_ready;

  logic              cfg_we;
  logic              cfg_sel;
  logic [ADDR_W-1:0] cfg_addr;
  logic [ADDR_W-1:0] cfg_data;

  logic              uaddr_valid;
  logic [ADDR_W-1:0] uaddr;
  logic              uaddr_ready;

  logic              seq_done;
  logic              illegal;
  logic              busy;

  modport master (
    output op_valid, op_data,
    output cfg_we, cfg_sel, cfg_addr, cfg_data,
    output uaddr_ready,
    input  op_ready, uaddr_valid, uaddr, seq_done, illegal, busy
  );

  modport slave (
    input  op_valid, op_data,
    input  cfg_we, cfg_sel, cfg_addr, cfg_data,
    input  uaddr_ready,
    output op_ready, uaddr_valid, uaddr, seq_done, illegal, busy
  );
endinterface

// File: rtl/ucode_sequencer.sv
// Purpose : microcode sequencer; maps an opcode through a writable dispatch
//           table, then walks a writable next-address table, emitting one
//           micro-address per accepted beat.
// Latency : first micro-address valid the cycle after opcode acceptance; one
//           beat per cycle while uaddr_ready is high; seq_done/illegal pulse
//           the cycle after the terminating edge.
// Backpres: uaddr/uaddr_valid held stable while uaddr_ready is low; op_ready
//           only in IDLE with no table write in progress.
// Ports   : clk, rst (async, active-high), bus (ucode_sequencer_if.slave).
// Tables  : entry 0 = end of chain, all-ones = invalid. Each entry carries a
//           valid bit cleared by reset; an unwritten entry reads as all-ones.
//           OP_W must not exceed ADDR_W (dispatch index is cfg_addr low bits).
module ucode_sequencer #(
  parameter int OP_W      = 9,
  parameter int ADDR_W    = 9,
  parameter int MAX_STEPS = 64
) (
  input  logic               clk,
  input  logic               rst,
  ucode_sequencer_if.slave   bus
);

  localparam int DISP_DEPTH = 1 << OP_W;
  localparam int NEXT_DEPTH = 1 << ADDR_W;
  localparam int STEP_W     = $clog2(MAX_STEPS + 1);

  localparam logic [ADDR_W-1:0] END_ADDR  = '0;
  localparam logic [ADDR_W-1:0] ALL_ONES  = '1;
  localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] upc_q;
  logic [STEP_W-1:0] step_q;
  logic              uaddr_valid_q;
  logic              seq_done_q;
  logic              illegal_q;
  logic              busy_q;

  // ---------------------------------------------------------------------------
  // Tables: valid bits are reset, payload storage is not (the valid bit masks
  // whatever the payload holds after reset).
  // ---------------------------------------------------------------------------
  logic [DISP_DEPTH-1:0] disp_vld_q;
  logic [NEXT_DEPTH-1:0] next_vld_q;
  logic [ADDR_W-1:0]     disp_mem [DISP_DEPTH];
  logic [ADDR_W-1:0]     next_mem [NEXT_DEPTH];

  logic [OP_W-1:0]   cfg_op_idx;
  logic              cfg_wr;
  logic [ADDR_W-1:0] disp_rd;
  logic [ADDR_W-1:0] next_rd;
  logic              op_ready;
  logic              op_fire;

  assign cfg_op_idx = OP_W'(bus.cfg_addr);
  // Writes are honoured only in IDLE so a running chain sees frozen tables.
  assign cfg_wr     = bus.cfg_we && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_vld_q <= '0;
      next_vld_q <= '0;
    end else if (cfg_wr) begin
      if (bus.cfg_sel) begin
        next_vld_q[bus.cfg_addr] <= 1'b1;
      end else begin
        disp_vld_q[cfg_op_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cfg_wr) begin
      if (bus.cfg_sel) begin
        next_mem[bus.cfg_addr] <= bus.cfg_data;
      end else begin
        disp_mem[cfg_op_idx] <= bus.cfg_data;
      end
    end
  end

  // Combinational lookups; unwritten entries read as the invalid marker.
  assign disp_rd = disp_vld_q[bus.op_data] ? disp_mem[bus.op_data] : ALL_ONES;
  assign next_rd = next_vld_q[upc_q]       ? next_mem[upc_q]       : ALL_ONES;

  // A write cycle never accepts an opcode; nothing is accepted under reset.
  assign op_ready = (state_q == IDLE) && !bus.cfg_we && !rst;
  assign op_fire  = bus.op_valid && op_ready;

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      upc_q         <= '0;
      step_q        <= '0;
      uaddr_valid_q <= 1'b0;
      seq_done_q    <= 1'b0;
      illegal_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      seq_done_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (op_fire) begin
            if ((disp_rd == END_ADDR) || (disp_rd == ALL_ONES)) begin
              illegal_q <= 1'b1;
            end else begin
              state_q       <= RUN;
              upc_q         <= disp_rd;
              step_q        <= STEP_ONE;
              uaddr_valid_q <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.uaddr_ready) begin
            // Priority: normal end, broken link, then runaway guard.
            if (next_rd == END_ADDR) begin
              seq_done_q    <= 1'b1;
              state_q       <= IDLE;
              uaddr_valid_q <= 1'b0;
              busy_q        <= 1'b0;
            end else if (next_rd == ALL_ONES) begin
              illegal_q     <= 1'b1;
              state_q       <= IDLE;
              uaddr_valid_q <= 1'b0;
              busy_q        <= 1'b0;
            end else if (step_q == STEP_MAX) begin
              illegal_q     <= 1'b1;
              state_q       <= IDLE;
              uaddr_valid_q <= 1'b0;
              busy_q        <= 1'b0;
            end else begin
              // step_q < STEP_MAX here, so the increment cannot wrap.
              upc_q  <= next_rd;
              step_q <= step_q + STEP_ONE;
            end
          end
        end

        default: begin
          state_q       <= IDLE;
          uaddr_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready    = op_ready;
  assign bus.uaddr_valid = uaddr_valid_q;
  assign bus.uaddr       = upc_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.illegal     = illegal_q;
  assign bus.busy        = busy_q;

endmodule
